// File: rtl/sargantana_icache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sargantana_icache_pkg
// Brief    : Shared types and defaults for the Sargantana icache refill control.
// Revision : 1.0 - initial release
// ============================================================================
package sargantana_icache_pkg;

    localparam int DEFAULT_PMU_CNT_W = 32;

    typedef enum logic [2:0] {
        READ       = 3'd0,
        MISS_REQ   = 3'd1,
        MISS_FILL  = 3'd2,
        REPLAY     = 3'd3,
        TLB_MISS   = 3'd4,
        REPLAY_TLB = 3'd5,
        KILL_DRAIN = 3'd6,
        KILL_TLB   = 3'd7
    } ictrl_state_t;

endpackage
`default_nettype wire

// File: rtl/sargantana_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sargantana_sat_counter
// Brief    : Up-counter that sticks at all-ones instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module sargantana_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_count <= '0;
        end else if (clear_i) begin
            r_count <= '0;
        end else if (inc_i && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/sargantana_icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sargantana_icache_refill_ctrl
// Brief    : Icache control FSM: hit/miss/TLB-miss decision, multi-beat refill,
//            replay and kill-drain sequencing, plus saturating PMU counters.
// Revision : 1.0 - initial release
// ============================================================================
module sargantana_icache_refill_ctrl
    import sargantana_icache_pkg::*;
#(
    parameter int ICACHE_N_WAY = 4,
    parameter int FILL_BEATS   = 4,
    parameter int BEAT_W       = (FILL_BEATS > 1) ? $clog2(FILL_BEATS) : 1,
    parameter int PMU_CNT_W    = DEFAULT_PMU_CNT_W
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    cache_enable_i,
    input  logic                    flush_i,
    input  logic                    ireq_valid_i,
    input  logic                    ireq_kill_i,
    output logic                    iresp_ready_o,
    output logic                    iresp_valid_o,
    input  logic                    mmu_ex_valid_i,
    input  logic                    mmu_miss_i,
    input  logic                    mmu_ptw_valid_i,
    output logic                    treq_valid_o,
    input  logic [ICACHE_N_WAY-1:0] cline_hit_i,
    output logic                    cmp_enable_o,
    output logic                    cache_rd_ena_o,
    output logic                    cache_wr_ena_o,
    output logic [BEAT_W-1:0]       fill_beat_idx_o,
    output logic                    ifill_req_valid_o,
    input  logic                    ifill_req_ready_i,
    input  logic                    ifill_beat_valid_i,
    output logic                    replay_valid_o,
    output logic                    flush_en_o,
    output logic [PMU_CNT_W-1:0]    miss_cnt_o,
    output logic [PMU_CNT_W-1:0]    kill_cnt_o
);

    localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(FILL_BEATS - 1);

    ictrl_state_t      r_state, w_state_nxt;
    logic [BEAT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;
    logic              r_kill_pend, w_kill_pend_nxt;
    logic              r_drain_done, w_drain_done_nxt;

    logic w_hit, w_kill, w_req, w_last_beat;
    logic w_miss_inc, w_kill_inc;
    logic w_ready, w_valid, w_treq, w_cmp, w_rd, w_wr, w_ifill, w_replay, w_flush;

    assign w_hit       = |cline_hit_i;
    assign w_kill      = flush_i | ireq_kill_i;
    assign w_req       = ireq_valid_i;
    assign w_last_beat = (r_beat_cnt == C_LAST_BEAT);

    always_comb begin
        w_state_nxt      = r_state;
        w_beat_cnt_nxt   = r_beat_cnt;
        w_kill_pend_nxt  = r_kill_pend;
        w_drain_done_nxt = r_drain_done;
        w_miss_inc       = 1'b0;
        w_kill_inc       = 1'b0;
        w_ready          = 1'b0;
        w_valid          = 1'b0;
        w_treq           = 1'b0;
        w_cmp            = 1'b0;
        w_rd             = 1'b0;
        w_wr             = 1'b0;
        w_ifill          = 1'b0;
        w_replay         = 1'b0;
        w_flush          = 1'b0;

        case (r_state)
            READ: begin
                w_ready = 1'b1;
                w_cmp   = cache_enable_i;
                w_flush = flush_i;
                w_valid = w_req & ~w_kill & ((w_hit & ~mmu_miss_i) | mmu_ex_valid_i);
                if (w_req && !w_kill && !mmu_ex_valid_i) begin
                    if (mmu_miss_i) begin
                        w_state_nxt = TLB_MISS;
                    end else if (!w_hit) begin
                        w_state_nxt     = MISS_REQ;
                        w_miss_inc      = 1'b1;
                        w_kill_pend_nxt = 1'b0;
                    end
                end
            end

            // The request is never withdrawn; a kill only redirects where it ends up.
            MISS_REQ: begin
                w_ifill = 1'b1;
                if (ifill_req_ready_i) begin
                    w_beat_cnt_nxt   = '0;
                    w_kill_pend_nxt  = 1'b0;
                    w_drain_done_nxt = 1'b0;
                    if (r_kill_pend || w_kill) begin
                        w_state_nxt = KILL_DRAIN;
                        w_kill_inc  = 1'b1;
                    end else begin
                        w_state_nxt = MISS_FILL;
                    end
                end else if (w_kill) begin
                    w_kill_pend_nxt = 1'b1;
                end
            end

            // A beat arriving with a kill is consumed but not written.
            MISS_FILL: begin
                if (w_kill || mmu_ex_valid_i) begin
                    w_state_nxt = KILL_DRAIN;
                    w_kill_inc  = 1'b1;
                    if (ifill_beat_valid_i) begin
                        if (w_last_beat) begin
                            w_drain_done_nxt = 1'b1;
                        end else begin
                            w_beat_cnt_nxt = r_beat_cnt + BEAT_W'(1);
                        end
                    end
                end else if (ifill_beat_valid_i) begin
                    w_wr = 1'b1;
                    if (w_last_beat) begin
                        w_state_nxt = REPLAY;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + BEAT_W'(1);
                    end
                end
            end

            KILL_DRAIN: begin
                if (r_drain_done) begin
                    w_state_nxt      = READ;
                    w_drain_done_nxt = 1'b0;
                end else if (ifill_beat_valid_i) begin
                    if (w_last_beat) begin
                        w_state_nxt = READ;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + BEAT_W'(1);
                    end
                end
            end

            REPLAY: begin
                w_cmp       = cache_enable_i;
                w_rd        = ~w_kill;
                w_replay    = ~w_kill;
                w_state_nxt = READ;
            end

            TLB_MISS: begin
                if (mmu_ex_valid_i) begin
                    w_valid     = 1'b1;
                    w_state_nxt = READ;
                end else if (mmu_ptw_valid_i) begin
                    w_state_nxt = w_kill ? READ : REPLAY_TLB;
                end else if (w_kill) begin
                    w_state_nxt = KILL_TLB;
                end
            end

            REPLAY_TLB: begin
                w_treq      = ~w_kill;
                w_rd        = ~w_kill;
                w_replay    = 1'b1;
                w_state_nxt = READ;
            end

            KILL_TLB: begin
                if (mmu_ptw_valid_i) begin
                    w_state_nxt = READ;
                end
            end

            default: begin
                w_state_nxt = READ;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= READ;
            r_beat_cnt   <= '0;
            r_kill_pend  <= 1'b0;
            r_drain_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
            r_kill_pend  <= w_kill_pend_nxt;
            r_drain_done <= w_drain_done_nxt;
        end
    end

    // Outputs are forced low for the whole time reset is held.
    assign iresp_ready_o     = w_ready  & rstn_i;
    assign iresp_valid_o     = w_valid  & rstn_i;
    assign treq_valid_o      = w_treq   & rstn_i;
    assign cmp_enable_o      = w_cmp    & rstn_i;
    assign cache_rd_ena_o    = w_rd     & rstn_i;
    assign cache_wr_ena_o    = w_wr     & rstn_i;
    assign ifill_req_valid_o = w_ifill  & rstn_i;
    assign replay_valid_o    = w_replay & rstn_i;
    assign flush_en_o        = w_flush  & rstn_i;
    assign fill_beat_idx_o   = (w_wr & rstn_i) ? r_beat_cnt : '0;

    sargantana_sat_counter #(
        .WIDTH (PMU_CNT_W)
    ) u_miss_cnt (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .clear_i (1'b0),
        .inc_i   (w_miss_inc),
        .count_o (miss_cnt_o)
    );

    sargantana_sat_counter #(
        .WIDTH (PMU_CNT_W)
    ) u_kill_cnt (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .clear_i (1'b0),
        .inc_i   (w_kill_inc),
        .count_o (kill_cnt_o)
    );

endmodule
`default_nettype wire

// File: doc/sargantana_icache_refill_ctrl.md
Name: sargantana_icache_refill_ctrl

Overview:
Next-generation instruction-cache control FSM, sitting between the Lagarto fetch interface, the iTLB and the upper-level IFILL port.
- Generalises the single-response refill to a parametrised multi-beat line fill with a proper valid/ready IFILL request handshake.
- Adds a beat counter, a kill-drain path that absorbs in-flight beats, and saturating PMU counters.
- Decides hit/miss/TLB-miss per request and sequences fill, write, replay and kill.

Parameters:
ICACHE_N_WAY, 4, number of ways (width of cline_hit_i)
FILL_BEATS, 4, beats per line refill; power of two, 1..16
BEAT_W, max(1,$clog2(FILL_BEATS)), width of beat index
PMU_CNT_W, 32, width of PMU counters

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
cache_enable_i  in  1  cache enable from CSR
flush_i  in  1  flush request
ireq_valid_i  in  1  valid fetch request
ireq_kill_i  in  1  kill current request
iresp_ready_o  out  1  controller can accept a request
iresp_valid_o  out  1  valid fetch response (hit or exception)
mmu_ex_valid_i  in  1  translation exception
mmu_miss_i  in  1  TLB miss
mmu_ptw_valid_i  in  1  PTW response valid
treq_valid_o  out  1  translation re-request
cline_hit_i  in  ICACHE_N_WAY  per-way hit
cmp_enable_o  out  1  tag compare enable
cache_rd_ena_o  out  1  replay read enable
cache_wr_ena_o  out  1  write one fill beat
fill_beat_idx_o  out  BEAT_W  beat index for write
ifill_req_valid_o  out  1  IFILL request valid
ifill_req_ready_i  in  1  IFILL request accepted
ifill_beat_valid_i  in  1  one fill beat present
replay_valid_o  out  1  replay cycle
flush_en_o  out  1  forward flush to arrays
miss_cnt_o  out  PMU_CNT_W  saturating miss count
kill_cnt_o  out  PMU_CNT_W  saturating killed-miss count

Behaviour:
- Reset (async, rstn_i low): state READ, beat counter 0, PMU counters 0. All single-bit outputs are 0 while in reset and in any non-READ state unless listed below.
- Shorthands:
  - hit = |cline_hit_i
  - kill = flush_i | ireq_kill_i
  - req = ireq_valid_i
- READ:
  - iresp_ready_o = 1.
  - cmp_enable_o = cache_enable_i.
  - iresp_valid_o = req & !kill & ((hit & !mmu_miss_i) | mmu_ex_valid_i).
  - flush_en_o = flush_i.
  - Transitions:
    - req & !kill & !hit & !mmu_ex_valid_i & !mmu_miss_i -> MISS_REQ; miss_cnt_o +1.
    - req & !kill & mmu_miss_i & !mmu_ex_valid_i -> TLB_MISS.
    - else stay.
- MISS_REQ:
  - ifill_req_valid_o = 1, held until ifill_req_ready_i; never withdrawn.
  - Accepted: beat counter = 0; go to MISS_FILL, or KILL_DRAIN if kill seen in this state or in the accept cycle.
  - A kill arriving before acceptance is latched in a sticky flag; the request still completes, then the FSM drains.
- MISS_FILL:
  - Each ifill_beat_valid_i pulses cache_wr_ena_o = 1 with fill_beat_idx_o = counter, then the counter increments.
  - Last beat (counter == FILL_BEATS-1) -> REPLAY.
  - Kill -> KILL_DRAIN, with no write in the kill cycle.
  - mmu_ex_valid_i -> KILL_DRAIN.
- KILL_DRAIN:
  - Beats are consumed with cache_wr_ena_o = 0.
  - The last beat returns to READ; kill_cnt_o +1 on entry.
  - A kill that coincides with the last beat also goes through KILL_DRAIN.
- REPLAY: one cycle; cmp_enable_o = cache_enable_i, cache_rd_ena_o = replay_valid_o = !kill; -> READ.
- TLB_MISS:
  - mmu_ex_valid_i -> READ, with iresp_valid_o = 1.
  - kill & !mmu_ptw_valid_i -> KILL_TLB.
  - mmu_ptw_valid_i & !kill -> REPLAY_TLB.
  - mmu_ptw_valid_i & kill -> READ.
- REPLAY_TLB: one cycle; treq_valid_o = cache_rd_ena_o = !kill; replay_valid_o = 1; -> READ.
- KILL_TLB: wait for mmu_ptw_valid_i -> READ.
- Counters: saturate at all-ones and never wrap. The beat counter wraps to 0 only via reload.
- FILL_BEATS = 1: the first beat is also the last; BEAT_W = 1 and fill_beat_idx_o = 0.
- Illegal state encodings -> READ with all outputs 0.

Decomposition:
- Package sargantana_icache_pkg holds:
  - ictrl_state_t: READ, MISS_REQ, MISS_FILL, REPLAY, TLB_MISS, REPLAY_TLB, KILL_DRAIN, KILL_TLB; 3 bits.
  - PMU_CNT_W default.
- One sub-module, sargantana_sat_counter (parametrised width, inc, clear), instantiated twice.

Test Plan:
- Hit: READ, req=1, cline_hit_i=4'b0010 -> iresp_valid_o=1 same cycle, no IFILL, miss_cnt_o=0.
- Miss with FILL_BEATS=4: ready held low 3 cycles -> ifill_req_valid_o held 4 cycles; 4 beats -> cache_wr_ena_o x4 with idx 0,1,2,3; REPLAY cycle rd_ena=1; miss_cnt_o=1.
- Kill after 2 beats -> remaining 2 beats absorbed with wr_ena=0, return to READ, kill_cnt_o=1, no replay.
- TLB miss then kill before PTW -> KILL_TLB; PTW pulse -> READ, treq_valid_o never asserted.
- Reset asserted mid-MISS_FILL (beat 2) -> all outputs 0 immediately, state READ, counters 0.
- PMU_CNT_W=2, 5 misses -> miss_cnt_o=3 (saturated).
